// File: rtl/mpu6050_pkg.sv
// Shared constants for the MPU-6050 command sequencer: device/register map,
// FSM state encoding and the order of the seven sample words.
package mpu6050_pkg;

  localparam logic [6:0] MPU_DEV_ADDR     = 7'h68;
  localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] REG_WHO_AM_I     = 8'h75;
  localparam logic [7:0] PWR_WAKE_VALUE   = 8'h00;

  localparam int MPU_NUM_BYTES = 14;
  localparam int MPU_NUM_WORDS = 7;

  localparam int W_ACCEL_X = 0;
  localparam int W_ACCEL_Y = 1;
  localparam int W_ACCEL_Z = 2;
  localparam int W_TEMP    = 3;
  localparam int W_GYRO_X  = 4;
  localparam int W_GYRO_Y  = 5;
  localparam int W_GYRO_Z  = 6;

  typedef enum logic [2:0] {
    ST_WAIT_INIT = 3'd0,
    ST_INIT_WR   = 3'd1,
    ST_IDLE      = 3'd2,
    ST_RD_PTR    = 3'd3,
    ST_RD_DATA   = 3'd4,
    ST_UPDATE    = 3'd5,
    ST_ERR       = 3'd6
  } state_e;

endpackage

// File: rtl/mpu6050_tick_gen.sv
// Modulo-MODULUS counter; tick is high for the cycle in which the count sits
// at MODULUS-1 while enabled, and the count wraps to zero on that edge.
module mpu6050_tick_gen #(
  parameter int unsigned MODULUS = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (MODULUS > 1) ? $clog2(MODULUS) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (en) begin
      if (cnt_q == CW'(MODULUS - 1)) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mpu6050_ctrl.sv
// MPU-6050 command sequencer: wakes the sensor, then burst-reads the 14 sample
// bytes each sample tick through an I2C byte master and publishes 7 words.
module mpu6050_ctrl
  import mpu6050_pkg::*;
#(
  parameter int unsigned        FPGA_CLK  = 50_000_000,
  parameter int unsigned        SAMPLE_HZ = 1_000,
  parameter int unsigned        INIT_DLY  = 5_000_000,
  parameter int                 ADDR_SZ   = 7,
  parameter int                 DATA_SZ   = 8,
  parameter logic [ADDR_SZ-1:0] DEV_ADDR  = MPU_DEV_ADDR,
  parameter logic [DATA_SZ-1:0] PWR_REG   = REG_PWR_MGMT_1,
  parameter logic [DATA_SZ-1:0] START_REG = REG_ACCEL_XOUT_H,
  parameter int                 NUM_BYTES = MPU_NUM_BYTES
) (
  input  logic               CLK,
  input  logic               RST_n,
  output logic               O_EN,
  output logic [ADDR_SZ-1:0] O_ADDR,
  output logic               O_RW,
  output logic [DATA_SZ-1:0] O_DATA_WR,
  input  logic               I_BUSY,
  input  logic [DATA_SZ-1:0] I_DATA_RD,
  input  logic               I_ACK_FL,
  output logic [15:0]        O_ACCEL_X,
  output logic [15:0]        O_ACCEL_Y,
  output logic [15:0]        O_ACCEL_Z,
  output logic [15:0]        O_TEMP,
  output logic [15:0]        O_GYRO_X,
  output logic [15:0]        O_GYRO_Y,
  output logic [15:0]        O_GYRO_Z,
  output logic               O_VALID,
  output logic               O_ERR,
  output logic               O_INIT_DONE,
  output logic [2:0]         O_DBG_STATE
);

  localparam int unsigned TICK  = FPGA_CLK / SAMPLE_HZ;
  localparam int          CNT_W = $clog2(NUM_BYTES + 2);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               en_q, en_d;
  logic               rw_q, rw_d;
  logic [DATA_SZ-1:0] data_wr_q, data_wr_d;
  logic [CNT_W-1:0]   rise_cnt_q, rise_cnt_d;
  logic [CNT_W-1:0]   fall_cnt_q, fall_cnt_d;
  logic [DATA_SZ-1:0] buf_q [NUM_BYTES];
  logic [DATA_SZ-1:0] buf_d [NUM_BYTES];
  logic [15:0]        word_q [MPU_NUM_WORDS];
  logic [15:0]        word_d [MPU_NUM_WORDS];
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               init_done_q, init_done_d;

  logic rise, fall, active;
  logic init_tick, sample_tick;

  mpu6050_tick_gen #(.MODULUS(INIT_DLY)) u_init_dly (
    .clk   (CLK),
    .rst_n (RST_n),
    .en    (state_q == ST_WAIT_INIT),
    .tick  (init_tick)
  );

  mpu6050_tick_gen #(.MODULUS(TICK)) u_sample_tick (
    .clk   (CLK),
    .rst_n (RST_n),
    .en    (1'b1),
    .tick  (sample_tick)
  );

  // Master handshake: a BUSY rise means the master latched EN/RW/DATA_WR, so
  // the next byte (or EN=0 after the last) is presented on that edge; a BUSY
  // fall means one byte finished, and the fall seen with EN=0 ends the transfer.
  assign busy_d = I_BUSY;
  assign rise   = I_BUSY & ~busy_q;
  assign fall   = ~I_BUSY & busy_q;
  assign active = (state_q == ST_INIT_WR) || (state_q == ST_RD_PTR) ||
                  (state_q == ST_RD_DATA);

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    rw_d        = rw_q;
    data_wr_d   = data_wr_q;
    rise_cnt_d  = rise_cnt_q;
    fall_cnt_d  = fall_cnt_q;
    buf_d       = buf_q;
    word_d      = word_q;
    valid_d     = 1'b0;
    err_d       = err_q;
    init_done_d = init_done_q;

    if (rise) rise_cnt_d = rise_cnt_q + 1'b1;
    if (fall) fall_cnt_d = fall_cnt_q + 1'b1;

    unique case (state_q)
      ST_WAIT_INIT: begin
        if (init_tick) begin
          state_d    = ST_INIT_WR;
          en_d       = 1'b1;
          rw_d       = 1'b0;
          data_wr_d  = PWR_REG;
          rise_cnt_d = '0;
          fall_cnt_d = '0;
        end
      end
      ST_INIT_WR: begin
        if (rise) begin
          if (rise_cnt_q == '0) data_wr_d = DATA_SZ'(PWR_WAKE_VALUE);
          else                  en_d      = 1'b0;
        end
        if (fall && !en_q) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (sample_tick) begin
          state_d    = ST_RD_PTR;
          en_d       = 1'b1;
          rw_d       = 1'b0;
          data_wr_d  = START_REG;
          rise_cnt_d = '0;
          fall_cnt_d = '0;
        end
      end
      ST_RD_PTR: begin
        // Switching RW while EN stays high makes the master issue a repeated start.
        if (rise) begin
          rw_d    = 1'b1;
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (rise && rise_cnt_q == CNT_W'(NUM_BYTES)) en_d = 1'b0;
        if (fall && !I_ACK_FL) begin
          for (int i = 0; i < NUM_BYTES; i++) begin
            if (fall_cnt_q == CNT_W'(i + 1)) buf_d[i] = I_DATA_RD;
          end
        end
        if (fall && !en_q) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        for (int i = 0; i < MPU_NUM_WORDS; i++) begin
          word_d[i] = {buf_q[2*i], buf_q[2*i+1]};
        end
        valid_d = 1'b1;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (!I_BUSY && sample_tick) begin
          en_d       = 1'b1;
          rw_d       = 1'b0;
          rise_cnt_d = '0;
          fall_cnt_d = '0;
          if (init_done_q) begin
            state_d   = ST_RD_PTR;
            data_wr_d = START_REG;
          end else begin
            state_d   = ST_INIT_WR;
            data_wr_d = PWR_REG;
          end
        end
      end
      default: state_d = ST_WAIT_INIT;
    endcase

    // A NACK on any byte aborts the transfer; already-published words stay put.
    if (active && fall && I_ACK_FL) begin
      state_d     = ST_ERR;
      en_d        = 1'b0;
      err_d       = 1'b1;
      init_done_d = init_done_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q     <= ST_WAIT_INIT;
      busy_q      <= 1'b0;
      en_q        <= 1'b0;
      rw_q        <= 1'b0;
      data_wr_q   <= '0;
      rise_cnt_q  <= '0;
      fall_cnt_q  <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
      for (int i = 0; i < NUM_BYTES; i++) buf_q[i] <= '0;
      for (int i = 0; i < MPU_NUM_WORDS; i++) word_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      en_q        <= en_d;
      rw_q        <= rw_d;
      data_wr_q   <= data_wr_d;
      rise_cnt_q  <= rise_cnt_d;
      fall_cnt_q  <= fall_cnt_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
      buf_q       <= buf_d;
      word_q      <= word_d;
    end
  end

  assign O_EN        = en_q;
  assign O_ADDR      = DEV_ADDR;
  assign O_RW        = rw_q;
  assign O_DATA_WR   = data_wr_q;
  assign O_ACCEL_X   = word_q[W_ACCEL_X];
  assign O_ACCEL_Y   = word_q[W_ACCEL_Y];
  assign O_ACCEL_Z   = word_q[W_ACCEL_Z];
  assign O_TEMP      = word_q[W_TEMP];
  assign O_GYRO_X    = word_q[W_GYRO_X];
  assign O_GYRO_Y    = word_q[W_GYRO_Y];
  assign O_GYRO_Z    = word_q[W_GYRO_Z];
  assign O_VALID     = valid_q;
  assign O_ERR       = err_q;
  assign O_INIT_DONE = init_done_q;
  assign O_DBG_STATE = state_q;

endmodule

// File: tb/tb_mpu6050_ctrl.sv
// Bench for mpu6050_ctrl: behavioural I2C byte-master model with a per-byte
// scoreboard, table-driven and random sample frames, plus NACK/drop/reset cases.
module tb_mpu6050_ctrl;
  import mpu6050_pkg::*;

  localparam int TICK     = 2000;
  localparam int INIT_DLY = 10;
  localparam int NB       = 14;
  localparam int BUDGET   = 8000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_busy = 1'b0;
  logic [7:0]  i_data_rd = 8'h00;
  logic        i_ack_fl = 1'b0;
  logic        o_en, o_rw, o_valid, o_err, o_init_done;
  logic [6:0]  o_addr;
  logic [7:0]  o_data_wr;
  logic [15:0] o_ax, o_ay, o_az, o_temp, o_gx, o_gy, o_gz;
  logic [2:0]  o_dbg_state;

  always #5 clk = ~clk;

  mpu6050_ctrl #(
    .FPGA_CLK  (2_000_000),
    .SAMPLE_HZ (1_000),
    .INIT_DLY  (INIT_DLY)
  ) dut (
    .CLK         (clk),
    .RST_n       (rst_n),
    .O_EN        (o_en),
    .O_ADDR      (o_addr),
    .O_RW        (o_rw),
    .O_DATA_WR   (o_data_wr),
    .I_BUSY      (i_busy),
    .I_DATA_RD   (i_data_rd),
    .I_ACK_FL    (i_ack_fl),
    .O_ACCEL_X   (o_ax),
    .O_ACCEL_Y   (o_ay),
    .O_ACCEL_Z   (o_az),
    .O_TEMP      (o_temp),
    .O_GYRO_X    (o_gx),
    .O_GYRO_Y    (o_gy),
    .O_GYRO_Z    (o_gz),
    .O_VALID     (o_valid),
    .O_ERR       (o_err),
    .O_INIT_DONE (o_init_done),
    .O_DBG_STATE (o_dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  int valid_cnt = 0;

  // Shared between the test sequence and the master model.
  logic [7:0] frame_bytes [NB];
  logic [9:0] exp_q [$];
  bit         inject_ack = 0;
  bit         ack_seen = 0;
  bit         stretch = 0;
  bit         model_init_done = 0;
  int         m_rd_idx = 0;
  int         start_cnt = 0;

  always @(posedge clk) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
    if (o_valid) valid_cnt <= valid_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_word(input int w);
    return 16'(frame_bytes[2*w]) * 16'd256 + 16'(frame_bytes[2*w+1]);
  endfunction

  function automatic logic [15:0] get_word(input int w);
    case (w)
      0: return o_ax;
      1: return o_ay;
      2: return o_az;
      3: return o_temp;
      4: return o_gx;
      5: return o_gy;
      default: return o_gz;
    endcase
  endfunction

  task automatic load_bytes(input logic [NB*8-1:0] v);
    for (int i = 0; i < NB; i++) frame_bytes[i] = v[(NB-1-i)*8 +: 8];
  endtask

  task automatic wait_valid(input string tag, output bit got);
    got = 0;
    for (int i = 0; i < BUDGET; i++) begin
      step();
      if (o_valid) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_valid_timeout: no O_VALID within %0d cycles", tag, BUDGET);
    end
  endtask

  task automatic wait_busy(input string tag, input logic level, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (i_busy == level) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_busy_timeout: I_BUSY never reached %0b", tag, level);
    end
  endtask

  task automatic check_frame(input string tag);
    for (int w = 0; w < MPU_NUM_WORDS; w++)
      check($sformatf("%s_word%0d", tag, w), {16'h0, get_word(w)}, {16'h0, exp_word(w)});
    check({tag, "_err_clear"}, o_err, 1'b0);
    step();
    check({tag, "_valid_one_cycle"}, o_valid, 1'b0);
  endtask

  // Behavioural byte master: BUSY rises 2 cycles after EN is seen, falls 20
  // cycles later; a transfer ends when EN is low at the next would-be rise.
  initial begin
    int ph, wcnt, hold, hold_len;
    bit aborted, cur_init, lat_rw;
    logic [9:0] e;
    ph = 0; wcnt = 0; hold = 0; hold_len = 20;
    aborted = 0; cur_init = 0; lat_rw = 0;
    forever begin
      @(negedge clk);
      i_ack_fl = 1'b0;
      if (!rst_n) begin
        ph = 0;
        i_busy = 1'b0;
        exp_q.delete();
        model_init_done = 0;
        m_rd_idx = 0;
      end else begin
        case (ph)
          0: if (o_en) begin
            start_cnt++;
            if (!model_init_done) begin
              check("init_start_cycle", edge_cnt, INIT_DLY);
              cur_init = 1;
              exp_q.push_back({1'b1, 1'b0, 8'h6B});
              exp_q.push_back({1'b1, 1'b0, 8'h00});
            end else begin
              check("frame_start_on_tick", edge_cnt % TICK, 0);
              cur_init = 0;
              exp_q.push_back({1'b1, 1'b0, 8'h3B});
              for (int i = 0; i < NB; i++) exp_q.push_back({1'b0, 1'b1, 8'h00});
            end
            check("addr", {25'h0, o_addr}, 32'h68);
            aborted = 0;
            m_rd_idx = 0;
            wcnt = 0;
            ph = 1;
          end
          1: begin
            wcnt++;
            if (wcnt == 2) begin
              if (o_en) begin
                if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL extra_byte: EN still high after %0s transfer", cur_init ? "init" : "read");
                  lat_rw = o_rw;
                end else begin
                  e = exp_q.pop_front();
                  check("latched_rw", o_rw, e[8]);
                  if (e[9]) check("latched_data", o_data_wr, e[7:0]);
                  lat_rw = e[8];
                end
                i_busy = 1'b1;
                hold = 0;
                hold_len = (stretch && lat_rw) ? TICK + 500 : 20;
                if (stretch && lat_rw) stretch = 0;
                ph = 2;
              end else begin
                if (!aborted) begin
                  check("bytes_per_transfer", exp_q.size(), 0);
                  if (cur_init) model_init_done = 1;
                end
                exp_q.delete();
                ph = 0;
              end
            end
          end
          default: begin
            hold++;
            if (hold == hold_len) begin
              i_busy = 1'b0;
              if (lat_rw) begin
                i_data_rd = (m_rd_idx < NB) ? frame_bytes[m_rd_idx] : 8'hEE;
                m_rd_idx++;
              end
              if (inject_ack) begin
                i_ack_fl = 1'b1;
                inject_ack = 0;
                aborted = 1;
                ack_seen = 1;
              end
              wcnt = 0;
              ph = 1;
            end
          end
        endcase
      end
    end
  end

  typedef struct packed {
    logic [NB*8-1:0] bytes;
    logic [15:0]     ax;
    logic [15:0]     tmp;
    logic [15:0]     gz;
  } vec_t;

  initial begin
    vec_t vecs [3];
    bit got;
    int en_hi, v0, s0;
    logic [15:0] prev [MPU_NUM_WORDS];

    vecs[0] = '{112'h0102030405060708090A0B0C0D0E, 16'h0102, 16'h0708, 16'h0D0E};
    vecs[1] = '{112'hFF381122334455667788_99AABBCC, 16'hFF38, 16'h5566, 16'hBBCC};
    vecs[2] = '{112'h80007FFF0001FFFF1234ABCD00FF, 16'h8000, 16'hFFFF, 16'h00FF};
    load_bytes(vecs[0].bytes);

    // Reset state
    repeat (3) step();
    check("rst_en", o_en, 1'b0);
    check("rst_addr", {25'h0, o_addr}, 32'h68);
    check("rst_rw", o_rw, 1'b0);
    check("rst_data_wr", o_data_wr, 8'h00);
    check("rst_valid", o_valid, 1'b0);
    check("rst_err", o_err, 1'b0);
    check("rst_init_done", o_init_done, 1'b0);
    check("rst_accel_x", o_ax, 16'h0);
    check("rst_state", o_dbg_state, ST_WAIT_INIT);

    // Startup delay then wake write
    @(negedge clk);
    rst_n = 1'b1;
    en_hi = 0;
    for (int i = 0; i < INIT_DLY - 1; i++) begin
      step();
      if (o_en) en_hi++;
    end
    check("init_en_early_cycles", en_hi, 0);
    step();
    check("init_en", o_en, 1'b1);
    check("init_rw", o_rw, 1'b0);
    check("init_data_pwr", o_data_wr, 8'h6B);
    check("init_state", o_dbg_state, ST_INIT_WR);
    wait_busy("init_rise1", 1'b1, 20);
    check("init_data_wake", o_data_wr, 8'h00);
    check("init_en_after_rise1", o_en, 1'b1);
    wait_busy("init_fall1", 1'b0, 40);
    wait_busy("init_rise2", 1'b1, 20);
    check("init_en_after_rise2", o_en, 1'b0);
    check("init_done_before_fall", o_init_done, 1'b0);
    for (int i = 0; i < 100 && !o_init_done; i++) step();
    check("init_done", o_init_done, 1'b1);
    check("init_valid_quiet", o_valid, 1'b0);

    // Table-driven frames
    for (int v = 0; v < 3; v++) begin
      load_bytes(vecs[v].bytes);
      wait_valid($sformatf("vec%0d", v), got);
      if (got) begin
        check($sformatf("vec%0d_accel_x", v), o_ax, vecs[v].ax);
        check($sformatf("vec%0d_temp", v), o_temp, vecs[v].tmp);
        check($sformatf("vec%0d_gyro_z", v), o_gz, vecs[v].gz);
        if (v == 1) check("accel_x_negative", 32'($signed(o_ax)), -32'sd200);
        check_frame($sformatf("vec%0d", v));
      end
    end

    // Random frames against the byte-pairing model
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NB; i++) frame_bytes[i] = 8'($urandom_range(0, 255));
      wait_valid($sformatf("rnd%0d", r), got);
      if (got) check_frame($sformatf("rnd%0d", r));
    end

    // NACK on the first byte of a read frame
    for (int w = 0; w < MPU_NUM_WORDS; w++) prev[w] = get_word(w);
    ack_seen = 0;
    inject_ack = 1;
    for (int i = 0; i < BUDGET && !ack_seen; i++) step();
    check("nack_injected", ack_seen, 1'b1);
    check("nack_en_drop", o_en, 1'b0);
    check("nack_err", o_err, 1'b1);
    check("nack_state", o_dbg_state, ST_ERR);
    check("nack_valid", o_valid, 1'b0);
    for (int w = 0; w < MPU_NUM_WORDS; w++)
      check($sformatf("nack_word%0d_kept", w), {16'h0, get_word(w)}, {16'h0, prev[w]});
    for (int i = 0; i < NB; i++) frame_bytes[i] = 8'($urandom_range(0, 255));
    wait_valid("nack_recover", got);
    if (got) check_frame("nack_recover");

    // Frame longer than TICK: the tick during the frame is dropped
    v0 = valid_cnt;
    s0 = start_cnt;
    stretch = 1;
    for (int i = 0; i < NB; i++) frame_bytes[i] = 8'($urandom_range(0, 255));
    wait_valid("long_frame", got);
    if (got) check_frame("long_frame");
    for (int i = 0; i < NB; i++) frame_bytes[i] = 8'($urandom_range(0, 255));
    wait_valid("after_long", got);
    if (got) check_frame("after_long");
    check("long_valid_count", valid_cnt - v0, 2);
    check("long_start_count", start_cnt - s0, 2);

    // Reset in the middle of the data phase
    for (int i = 0; i < BUDGET && m_rd_idx < 3; i++) step();
    check("mid_reset_reached_data", (m_rd_idx >= 3), 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    step();
    check("mid_reset_en", o_en, 1'b0);
    check("mid_reset_valid", o_valid, 1'b0);
    check("mid_reset_state", o_dbg_state, ST_WAIT_INIT);
    check("mid_reset_init_done", o_init_done, 1'b0);
    for (int w = 0; w < MPU_NUM_WORDS; w++)
      check($sformatf("mid_reset_word%0d", w), {16'h0, get_word(w)}, 32'h0);
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200 && !o_init_done; i++) step();
    check("reinit_done", o_init_done, 1'b1);
    load_bytes(vecs[0].bytes);
    wait_valid("post_reset", got);
    if (got) check_frame("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
